// File: rtl/if_stage_ifid_pkg.sv
// Shared pipeline package: instruction constants, default reset PC and
// instruction field positions used by fetch, hazard detection and forwarding.
package if_stage_ifid_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;
    localparam int          RS_LSB           = 21;
    localparam int          RT_LSB           = 16;

endpackage : if_stage_ifid_pkg

// File: rtl/if_stage_ifid_pipe_reg_en_clr.sv
// Generic pipeline register: async active-low reset, synchronous clear
// (higher priority than enable) and load enable. Shared by all pipeline
// boundaries of the core.
module pipe_reg_en_clr #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset, then clear, then load, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : pipe_reg_en_clr

// File: rtl/if_stage_ifid.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register. Redirects (branch or jump) override stalls and flush
// IF/ID to a NOP bubble.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module if_stage_ifid
    import if_stage_ifid_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_write,
    input  logic               ifid_write,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_plus4,
    output logic               ifid_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    logic [ADDR_W-1:0] pc_p0;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target_sel;
    logic [ADDR_W-1:0] pc_next;
    logic              pc_en;
    logic              redirect;

    // Next-PC selection: branch beats jump, redirect beats stall.
    always_comb begin
        pc_plus4   = pc_p0 + ADDR_W'(4);
        redirect   = branch_taken | jump;
        target_sel = branch_taken ? branch_target : jump_target;
        target_sel = {target_sel[ADDR_W-1:2], 2'b00};
        pc_next    = redirect ? target_sel : pc_plus4;
        pc_en      = redirect | pc_write;
    end

    pipe_reg_en_clr #(.W(ADDR_W), .RST_VAL(PC_RESET), .CLR_VAL(PC_RESET)) u_pc (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pc_en),
        .clr  (1'b0),
        .d    (pc_next),
        .q    (pc_p0)
    );

    assign imem_addr = pc_p0;

    // ---- IF/ID boundary: flush on redirect, otherwise load under ifid_write ----
    pipe_reg_en_clr #(.W(INSTR_W), .RST_VAL(NOP_INSTR), .CLR_VAL(NOP_INSTR)) u_ifid_instr (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (ifid_write),
        .clr  (redirect),
        .d    (imem_rdata),
        .q    (ifid_instr)
    );

    pipe_reg_en_clr #(.W(ADDR_W), .RST_VAL('0), .CLR_VAL('0)) u_ifid_pc_plus4 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (ifid_write),
        .clr  (redirect),
        .d    (pc_plus4),
        .q    (ifid_pc_plus4)
    );

    pipe_reg_en_clr #(.W(1), .RST_VAL(1'b0), .CLR_VAL(1'b0)) u_ifid_valid (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (ifid_write),
        .clr  (redirect),
        .d    (1'b1),
        .q    (ifid_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Performance counters: stalls exclude redirect cycles; both saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (!pc_write && !redirect) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (redirect) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end
`endif

endmodule : if_stage_ifid
